serial_tx_feeder: RTL
=====================

// Module: serial_tx_feeder
// PURPOSE
//  Byte FIFO and handshake sequencer placed directly upstream of the UART
//  transmitter. Producers push bytes at any rate. The block pulses one byte
//  at a time into the transmitter's data/new_data inputs. It waits for the
//  transmitter's busy to rise and then fall before it issues the next byte,
//  so no byte is lost while the transmitter is blocked or busy.
// PARAMETERS
//  DEPTH   16  FIFO entries; power of two, >= 2
//  ADDR_W  $clog2(DEPTH)  pointer width (derived, do not override)
// PORTS
//  clk          in   1         single clock, all logic on posedge
//  rst          in   1         reset, asynchronous, active-low
//  wr_data      in   8         byte to enqueue
//  wr_en        in   1         enqueue strobe, one byte per cycle high
//  flush        in   1         sync clear of FIFO contents and overflow flag
//  full         out  1         count == DEPTH
//  empty        out  1         count == 0
//  level        out  ADDR_W+1  bytes currently queued, 0..DEPTH
//  overflow     out  1         sticky: a write was dropped while full
//  tx_data      out  8         byte presented to transmitter
//  tx_new_data  out  1         one-cycle strobe: tx_data is valid
//  tx_busy      in   1         transmitter busy, registered in transmitter
//  tx_block     in   1         same signal that drives transmitter block input
// BEHAVIOUR
//  Reset (rst=0, async):
//  - FIFO pointers and count = 0; state = IDLE.
//  - Outputs: tx_new_data = 0, tx_data = 8'h00, overflow = 0, empty = 1,
//    full = 0, level = 0.
//  - Reset mid-transfer abandons the in-flight byte.
//  FIFO:
//  - Write on wr_en & !full. Wrap-around is a natural ADDR_W-bit pointer
//    rollover.
//  - wr_en & full with no pop in the same cycle: byte is dropped and
//    overflow is set.
//  - wr_en & full with a pop in the same cycle: write is accepted and the
//    count is unchanged.
//  - A write into an empty FIFO is visible to the sequencer on the next edge.
//    There is no same-cycle bypass.
//  - flush has priority over wr_en in the same cycle.
//  - flush clears count, pointers and overflow. It does not touch the
//    sequencer: an already-popped byte still completes.
//  Sequencer states:
//  - IDLE:
//    - Go when !empty & !tx_busy & !tx_block.
//    - On go: pop the head, register tx_data = head, drive tx_new_data = 1
//      for exactly one cycle, then move to ACK.
//    - tx_block is checked one cycle early. This covers the transmitter
//      registering block one cycle late, so a strobe is never issued into a
//      blocked transmitter.
//  - ACK:
//    - tx_new_data = 0.
//    - Move to DRAIN when tx_busy = 1. The nominal wait is 1 cycle.
//    - Otherwise stay in ACK. There is no timeout, and the byte is never
//      re-sent.
//  - DRAIN: move to IDLE when tx_busy = 0.
//  - tx_data holds its value from the pop until the next pop.
//  Timing:
//  - Minimum spacing between strobes is 4 cycles plus the transmitter busy
//    time: IDLE -> ACK -> DRAIN, then back through IDLE.
//  - Latency from wr_en (empty FIFO, idle transmitter) to tx_new_data is
//    2 edges.
// TESTING
//  1. Reset, then write 8'hA5 once.
//     -> tx_new_data high for 1 cycle, 2 edges later, with tx_data = A5.
//     -> level returns to 0.
//  2. Write 3 bytes back to back: 01, 02, 03. Use a transmitter model with
//     busy high for 40 cycles per byte.
//     -> Exactly 3 strobes, in order, none while tx_busy = 1.
//  3. Fill to DEPTH with no draining (hold tx_block = 1), then write 8'hFF.
//     -> full = 1, overflow = 1, level = DEPTH, FF not stored.
//     -> Release block: DEPTH bytes are sent, and FF is not among them.
//  4. Full FIFO plus a simultaneous write and pop.
//     -> level stays DEPTH, overflow stays 0, the new byte is sent last.
//  5. flush during DRAIN with 5 bytes queued.
//     -> level = 0 and overflow = 0 the next cycle.
//     -> In-flight byte completes, and no further strobes follow.
//  6. Drop rst while in ACK.
//     -> All outputs are at reset values immediately (async).
//     -> After release, state = IDLE and empty = 1.

Source files
------------

// File: rtl/serial_tx_feeder.sv
// serial_tx_feeder: byte FIFO feeding a UART transmitter one strobe at a time,
// waiting for busy to rise and fall before issuing the next byte.
module serial_tx_feeder #(
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic [7:0]        tx_data,
  output logic              tx_new_data,
  input  logic              tx_busy,
  input  logic              tx_block
);
  typedef enum logic [1:0] {IDLE, ACK, DRAIN} state_t;
  state_t state, state_nxt;
  logic [7:0] mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr, wr_ptr;
  logic [ADDR_W:0] count;
  logic pop, push;
  assign full  = count == (ADDR_W+1)'(DEPTH);
  assign empty = count == '0;
  assign level = count;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (pop ? ACK : IDLE) :
                state == ACK  ? (tx_busy ? DRAIN : ACK) :
                                (tx_busy ? DRAIN : IDLE);
  // tx_block is sampled one cycle ahead of the strobe to cover the
  // transmitter registering block late.
  always_comb begin
    pop  = state == IDLE && !empty && !tx_busy && !tx_block;
    push = wr_en && !flush && (!full || pop);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
      if (wr_en && full && !pop) overflow <= 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
  // Flush leaves this path alone so an already-popped byte still completes.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tx_data     <= 8'h00;
      tx_new_data <= 1'b0;
    end else begin
      tx_new_data <= pop;
      if (pop) tx_data <= mem[rd_ptr];
    end
endmodule
